// File: rtl/tex_stream_receiver.sv
// tex_stream_receiver: frames a NUL-terminated ASCII stream, buffers up to
// DEPTH characters, tracks a saturating length and a CRC-8, and holds the
// completed frame for host readout until acknowledged.
module tex_stream_receiver #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ch_in,
  input  logic             ch_valid,
  input  logic             rd_en,
  input  logic             ack,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_empty,
  output logic             frame_done,
  output logic             busy,
  output logic             ready,
  output logic [LEN_W-1:0] frame_len,
  output logic [7:0]       frame_crc,
  output logic             overflow,
  output logic             missed
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One extra bit so the write pointer can reach DEPTH (buffer full).
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_OVF  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // CRC-8, poly 0x07, MSB-first, one byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  logic [1:0]       state, state_nxt;
  logic [PW-1:0]    wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr, rd_ptr_nxt;
  logic [LEN_W-1:0] len_nxt, len_inc;
  logic [7:0]       crc_nxt, crc_upd;
  logic             ovf_nxt, missed_nxt;
  logic             wr_en, rd_fire, is_nul;
  logic [7:0]       mem [DEPTH];

  // Next-state, pointer, length and CRC decode.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    len_nxt    = frame_len;
    crc_nxt    = frame_crc;
    ovf_nxt    = overflow;
    missed_nxt = missed;
    wr_en      = 1'b0;
    rd_fire    = 1'b0;
    is_nul     = (ch_in == 8'h00);
    len_inc    = (frame_len == LEN_MAX) ? frame_len : frame_len + LEN_W'(1);
    crc_upd    = crc8_byte(frame_crc, ch_in);

    case (state)
      ST_IDLE: begin
        if (ch_valid && !is_nul) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = PW'(1);
          len_nxt    = LEN_W'(1);
          crc_nxt    = crc8_byte(8'h00, ch_in);
          state_nxt  = ST_RECV;
        end
      end
      ST_RECV: begin
        if (ch_valid) begin
          if (is_nul) begin
            state_nxt = ST_DONE;
          end else if (wr_ptr != PW'(DEPTH)) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            len_nxt    = len_inc;
            crc_nxt    = crc_upd;
          end else begin
            len_nxt   = len_inc;
            crc_nxt   = crc_upd;
            ovf_nxt   = 1'b1;
            state_nxt = ST_OVF;
          end
        end
      end
      ST_OVF: begin
        if (ch_valid) begin
          if (is_nul) begin
            state_nxt = ST_DONE;
          end else begin
            len_nxt = len_inc;
            crc_nxt = crc_upd;
          end
        end
      end
      default: begin
        // DONE: ack releases the frame and takes priority over a read.
        if (ack) begin
          wr_ptr_nxt = '0;
          rd_ptr_nxt = '0;
          len_nxt    = '0;
          crc_nxt    = 8'h00;
          ovf_nxt    = 1'b0;
          missed_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end else begin
          if (ch_valid) missed_nxt = 1'b1;
          if (rd_en && !rd_empty) begin
            rd_fire    = 1'b1;
            rd_ptr_nxt = rd_ptr + PW'(1);
          end
        end
      end
    endcase
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_len  <= '0;
      frame_crc  <= 8'h00;
      overflow   <= 1'b0;
      missed     <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      rd_empty   <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      frame_len  <= len_nxt;
      frame_crc  <= crc_nxt;
      overflow   <= ovf_nxt;
      missed     <= missed_nxt;
      rd_valid   <= rd_fire;
      if (rd_fire) rd_data <= mem[rd_ptr[AW-1:0]];
      rd_empty   <= (rd_ptr_nxt == wr_ptr_nxt);
      frame_done <= (state_nxt == ST_DONE) && (state != ST_DONE);
      busy       <= (state_nxt == ST_RECV) || (state_nxt == ST_OVF);
      ready      <= (state_nxt == ST_DONE);
    end
  end

  // Character buffer storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= ch_in;
  end

endmodule
